ifetch_stage: RTL

Instruction fetch stage directly upstream of the decode/immediate-extension stage.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/ack + rvalid handshake.
- Buffers returned words in a 2-entry FIFO and hands {pc, inst} to decode with valid/ready.
- Pre-classifies the immediate format, so id_sext_din/id_sext_op feed the sign-extension unit directly.

---
 rtl/ifetch_stage_pkg.sv | 41 ++++
 rtl/ifetch_stage_imm_type_dec.sv | 31 +++
 rtl/ifetch_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ifetch_stage_pkg.sv
// Shared constants for the fetch stage: immediate-format codes, RV32 opcodes,
// fetch FSM states and the FIFO entry layout.
package ifetch_stage_pkg;

   localparam logic [2:0] EXT_NONE  = 3'd0;
   localparam logic [2:0] EXT_I     = 3'd1;
   localparam logic [2:0] EXT_S     = 3'd2;
   localparam logic [2:0] EXT_B     = 3'd3;
   localparam logic [2:0] EXT_U     = 3'd4;
   localparam logic [2:0] EXT_J     = 3'd5;
   localparam logic [2:0] EXT_SHIFT = 3'd6;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SRX    = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_ent_t;

   // Wraps modulo 2^32 by construction.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifetch_stage_imm_type_dec.sv
// Combinational immediate-format classifier: instruction word -> EXT_* code
// consumed by the sign-extension unit in decode.
module imm_type_dec
   import ifetch_stage_pkg::*;
(
   input  logic [31:0] inst_i,
   output logic [2:0]  sext_op_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_bits;

   assign opcode      = inst_i[6:0];
   assign funct3      = inst_i[14:12];
   assign unused_bits = ^{inst_i[31:15], inst_i[11:7]};

   always_comb begin
      sext_op_o = EXT_NONE;
      case (opcode)
         OP_IMM:            sext_op_o = (funct3 == F3_SLL || funct3 == F3_SRX) ? EXT_SHIFT : EXT_I;
         OP_LOAD, OP_JALR:  sext_op_o = EXT_I;
         OP_STORE:          sext_op_o = EXT_S;
         OP_BRANCH:         sext_op_o = EXT_B;
         OP_LUI, OP_AUIPC:  sext_op_o = EXT_U;
         OP_JAL:            sext_op_o = EXT_J;
         default:           sext_op_o = EXT_NONE;
      endcase
   end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests, small output FIFO,
// immediate-format pre-decode. Optional IFETCH_MISALIGN_CHK_EN adds fetch_misalign.
module ifetch_stage
   import ifetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic [24:0] id_sext_din,
   output logic [2:0]  id_sext_op
`ifdef IFETCH_MISALIGN_CHK_EN
   ,
   output logic        fetch_misalign
`endif
);

   localparam int unsigned       PW      = $clog2(FIFO_DEPTH);
   localparam int unsigned       CW      = PW + 1;
   localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);

   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [31:0]   tgt_q, tgt_d;
   logic          redir_pend_q, redir_pend_d;
   logic          kill_q, kill_d;
   fetch_ent_t    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q, cnt_d, cnt_after;
   logic          push, pop;
   logic [31:0]   redir_tgt;
   fetch_ent_t    head;

`ifdef IFETCH_MISALIGN_CHK_EN
   logic misalign_q;

   assign redir_tgt      = {redirect_pc[31:2], 2'b00};
   assign fetch_misalign = misalign_q;

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n)
         misalign_q <= 1'b0;
      else if (redirect_valid && redirect_pc[1:0] != 2'b00)
         misalign_q <= 1'b1;
   end
`else
   assign redir_tgt = redirect_pc;
`endif

   // Redirect flushes the FIFO, so it outranks both push and pop.
   assign push      = (state_q == S_WAIT) && imem_rvalid && !kill_q && !redirect_valid;
   assign pop       = id_valid && id_ready && !redirect_valid;
   assign cnt_after = cnt_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
   assign cnt_d     = redirect_valid ? '0 : cnt_after;

   assign imem_addr = pc_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      tgt_d        = tgt_q;
      redir_pend_d = redir_pend_q;
      kill_d       = kill_q;
      imem_req     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (redirect_valid) begin
               pc_d    = redir_tgt;
               state_d = S_REQ;
            end else if (cnt_q < DEPTH_C) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               req_pc_d     = pc_q;
               state_d      = S_WAIT;
               redir_pend_d = 1'b0;
               if (redirect_valid) begin
                  pc_d   = redir_tgt;
                  kill_d = 1'b1;
               end else if (redir_pend_q) begin
                  pc_d   = tgt_q;
                  kill_d = 1'b1;
               end else begin
                  pc_d   = pc_inc(pc_q);
               end
            end else if (redirect_valid) begin
               // Address must stay put until ack; remember where to go afterwards.
               tgt_d        = redir_tgt;
               redir_pend_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               kill_d = 1'b0;
               if (redirect_valid) begin
                  pc_d    = redir_tgt;
                  state_d = S_REQ;
               end else begin
                  state_d = (cnt_after < DEPTH_C) ? S_REQ : S_IDLE;
               end
            end else if (redirect_valid) begin
               pc_d   = redir_tgt;
               kill_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         req_pc_q     <= RESET_PC;
         tgt_q        <= RESET_PC;
         redir_pend_q <= 1'b0;
         kill_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         tgt_q        <= tgt_d;
         redir_pend_q <= redir_pend_d;
         kill_q       <= kill_d;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge cpu_clk) begin
      if (push)
         fifo_q[wr_ptr_q] <= '{pc: req_pc_q, inst: imem_rdata};
   end

   assign head        = fifo_q[rd_ptr_q];
   assign id_valid    = (cnt_q != '0);
   assign id_pc       = id_valid ? head.pc   : 32'h0;
   assign id_inst     = id_valid ? head.inst : 32'h0;
   assign id_sext_din = id_inst[31:7];

   imm_type_dec u_imm_dec (
      .inst_i    (id_inst),
      .sext_op_o (id_sext_op)
   );

endmodule
